div_sequencer: RTL and testbench

Controls the shared divider for DIV/IDIV execution in the NEC core. It accepts one divide request at a time from the execute unit and formats the byte or word operands into the 32-bit signed/unsigned divider request. It drives the divider handshake, range-checks the quotient, and returns the quotient and remainder, or a divide-error trap, after a programmed, cycle-accurate instruction latency. It sits between the execute unit and `divider2`, and is the only master of `divider2`.

---
 rtl/nec_div_pkg.sv | 31 +++
 rtl/div_range_check.sv | 37 +++
 rtl/div_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_div_pkg.sv
// Shared types, default latencies and operand helpers for the DIV/IDIV sequencer.
package nec_div_pkg;

   localparam int LAT_BYTE = 14;
   localparam int LAT_WORD = 22;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PAD,
      S_RESP,
      S_DRAIN
   } div_state_t;

   typedef struct packed {
      logic        wide;
      logic        is_signed;
      logic [31:0] dividend;
      logic [15:0] divisor;
   } div_req_t;

   function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
      return {{24{sgn & v[7]}}, v};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
      return {{16{sgn & v[15]}}, v};
   endfunction

endpackage

// File: rtl/div_range_check.sv
// Quotient range check and result truncation for byte/word DIV and IDIV.
module div_range_check (
   input  logic        wide_i,
   input  logic        is_signed_i,
   input  logic        dbz_i,
   input  logic [31:0] quot_i,
   input  logic [31:0] rem_i,
   output logic        err_o,
   output logic [15:0] quot_o,
   output logic [15:0] rem_o
);

   logic ovf;
   logic unused_rem_hi;

   // The remainder is always smaller than the divisor, so its upper half is pure extension.
   assign unused_rem_hi = ^rem_i[31:16];

   always_comb begin
      ovf = 1'b0;
      if (wide_i) begin
         if (is_signed_i) ovf = !((&quot_i[31:15]) || !(|quot_i[31:15]));
         else             ovf = |quot_i[31:16];
      end else begin
         if (is_signed_i) ovf = !((&quot_i[31:7]) || !(|quot_i[31:7]));
         else             ovf = |quot_i[31:8];
      end
      err_o  = dbz_i | ovf;
      quot_o = '0;
      rem_o  = '0;
      if (!err_o) begin
         quot_o = wide_i ? quot_i[15:0] : {8'h00, quot_i[7:0]};
         rem_o  = wide_i ? rem_i[15:0]  : {8'h00, rem_i[7:0]};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Sequences one DIV/IDIV at a time through the shared divider with a fixed
// minimum instruction latency, range checking and abort/drain handling.
module div_sequencer #(
   parameter int LAT_BYTE = nec_div_pkg::LAT_BYTE,
   parameter int LAT_WORD = nec_div_pkg::LAT_WORD
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        abort,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wide,
   input  logic        req_signed,
   input  logic [31:0] req_dividend,
   input  logic [15:0] req_divisor,
   output logic        res_valid,
   output logic [15:0] res_quot,
   output logic [15:0] res_rem,
   output logic        res_err,
   output logic        res_dbz,
   output logic        div_ce,
   output logic        div_start,
   output logic        div_wide,
   output logic        div_is_signed,
   output logic [31:0] div_num,
   output logic [31:0] div_denom,
   input  logic        div_done,
   input  logic        div_dbz,
   input  logic [31:0] div_quot,
   input  logic [31:0] div_rem
);

   import nec_div_pkg::*;

   localparam int LAT_MAX = (LAT_WORD > LAT_BYTE) ? LAT_WORD : LAT_BYTE;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(LAT_BYTE - 1);
   localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(LAT_WORD - 1);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_dec;
   logic             done_seen_q;
   logic             done_any;
   logic [31:0]      quot_q, rem_q;
   logic             dbz_q;
   logic             wide_q, signed_q;
   logic [31:0]      num_q, denom_q, num_d, denom_d;
   logic             start_q;
   logic             res_valid_q, res_err_q, res_dbz_q;
   logic [15:0]      res_quot_q, res_rem_q;
   logic             chk_err;
   logic [15:0]      chk_quot, chk_rem;
   div_req_t         req;

   assign req = '{wide: req_wide, is_signed: req_signed,
                  dividend: req_dividend, divisor: req_divisor};

   always_comb begin
      num_d   = req.wide ? req.dividend : ext16(req.dividend[15:0], req.is_signed);
      denom_d = req.wide ? ext16(req.divisor, req.is_signed)
                         : ext8(req.divisor[7:0], req.is_signed);
   end

   assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
   // div_done may arrive while ce is low; the sticky flag keeps it for the next ce cycle.
   assign done_any = div_done | done_seen_q;

   div_range_check u_range (
      .wide_i      (wide_q),
      .is_signed_i (signed_q),
      .dbz_i       (dbz_q),
      .quot_i      (quot_q),
      .rem_i       (rem_q),
      .err_o       (chk_err),
      .quot_o      (chk_quot),
      .rem_o       (chk_rem)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         done_seen_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         wide_q      <= 1'b0;
         signed_q    <= 1'b0;
         num_q       <= '0;
         denom_q     <= '0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_dbz_q   <= 1'b0;
         res_quot_q  <= '0;
         res_rem_q   <= '0;
      end else begin
         res_valid_q <= 1'b0;
         if (div_done && (state_q == S_WAIT || state_q == S_DRAIN)) done_seen_q <= 1'b1;
         if (div_done && state_q == S_WAIT) begin
            quot_q <= div_quot;
            rem_q  <= div_rem;
            dbz_q  <= div_dbz;
         end
         if (ce && state_q != S_IDLE) cnt_q <= cnt_dec;

         // Abort is honoured regardless of ce; anything else moves only on ce.
         case (state_q)
            S_IDLE: begin
               if (ce && req_valid && !abort) begin
                  num_q       <= num_d;
                  denom_q     <= denom_d;
                  wide_q      <= req.wide;
                  signed_q    <= req.is_signed;
                  cnt_q       <= req.wide ? CNT_WORD : CNT_BYTE;
                  start_q     <= 1'b1;
                  done_seen_q <= 1'b0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (abort) begin
                  start_q <= 1'b0;
                  state_q <= ce ? S_DRAIN : S_IDLE;
               end else if (ce) begin
                  start_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (abort) begin
                  state_q <= done_any ? S_IDLE : S_DRAIN;
               end else if (ce && done_any) begin
                  done_seen_q <= 1'b0;
                  state_q     <= S_PAD;
               end
            end
            S_PAD: begin
               if (abort) state_q <= S_IDLE;
               else if (ce && cnt_dec == '0) state_q <= S_RESP;
            end
            S_RESP: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (ce) begin
                  res_valid_q <= 1'b1;
                  res_err_q   <= chk_err;
                  res_dbz_q   <= dbz_q;
                  res_quot_q  <= chk_quot;
                  res_rem_q   <= chk_rem;
                  state_q     <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (ce && done_any) begin
                  done_seen_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign div_ce        = ce;
   assign div_start     = start_q;
   assign div_wide      = wide_q;
   assign div_is_signed = signed_q;
   assign div_num       = num_q;
   assign div_denom     = denom_q;
   assign res_valid     = res_valid_q;
   assign res_err       = res_err_q;
   assign res_dbz       = res_dbz_q;
   assign res_quot      = res_quot_q;
   assign res_rem       = res_rem_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural stand-in for the shared divider.
module tb_div_sequencer;

   typedef struct {
      string       name;
      bit          wide;
      bit          sgn;
      logic [31:0] dividend;
      logic [15:0] divisor;
      int          divLat;
      logic [31:0] expNum;
      logic [31:0] expDenom;
      logic [15:0] expQuot;
      logic [15:0] expRem;
      bit          expErr;
      bit          expDbz;
      int          expCycles;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        ce = 1'b1;
   logic        abort = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wide = 1'b0;
   logic        req_signed = 1'b0;
   logic [31:0] req_dividend = '0;
   logic [15:0] req_divisor = '0;
   logic        res_valid, res_err, res_dbz;
   logic [15:0] res_quot, res_rem;
   logic        div_ce, div_start, div_wide, div_is_signed;
   logic [31:0] div_num, div_denom;

   logic        mDone, mDbz, mBusy;
   logic [31:0] mQuot, mRem;
   int          mRemain;
   int          divLat = 6;
   int          startCount = 0;
   bit          startWhileBusy = 1'b0;

   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   div_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ce            (ce),
      .abort         (abort),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wide      (req_wide),
      .req_signed    (req_signed),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .res_valid     (res_valid),
      .res_quot      (res_quot),
      .res_rem       (res_rem),
      .res_err       (res_err),
      .res_dbz       (res_dbz),
      .div_ce        (div_ce),
      .div_start     (div_start),
      .div_wide      (div_wide),
      .div_is_signed (div_is_signed),
      .div_num       (div_num),
      .div_denom     (div_denom),
      .div_done      (mDone),
      .div_dbz       (mDbz),
      .div_quot      (mQuot),
      .div_rem       (mRem)
   );

   // Divider stand-in: div_done rises divLat ce cycles after the div_start cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mDone   <= 1'b0;
         mBusy   <= 1'b0;
         mRemain <= 0;
         mQuot   <= '0;
         mRem    <= '0;
         mDbz    <= 1'b0;
      end else if (div_ce) begin
         mDone <= 1'b0;
         if (div_start) begin
            if (mBusy) startWhileBusy <= 1'b1;
            startCount <= startCount + 1;
            mBusy      <= 1'b1;
            mRemain    <= divLat - 1;
            if (div_denom == 32'd0) begin
               mQuot <= '0;
               mRem  <= '0;
               mDbz  <= 1'b1;
            end else if (div_is_signed) begin
               mQuot <= $signed(div_num) / $signed(div_denom);
               mRem  <= $signed(div_num) % $signed(div_denom);
               mDbz  <= 1'b0;
            end else begin
               mQuot <= div_num / div_denom;
               mRem  <= div_num % div_denom;
               mDbz  <= 1'b0;
            end
         end else if (mBusy) begin
            if (mRemain == 1) begin
               mDone <= 1'b1;
               mBusy <= 1'b0;
            end
            mRemain <= mRemain - 1;
         end
      end
   end

   function automatic vec_t mkVec(input string name, input bit wide, input bit sgn,
                                  input logic [31:0] dvd, input logic [15:0] dvs, input int lat,
                                  input logic [31:0] num, input logic [31:0] den,
                                  input logic [15:0] q, input logic [15:0] r,
                                  input bit err, input bit dbz, input int cyc);
      vec_t v;
      v.name = name; v.wide = wide; v.sgn = sgn; v.dividend = dvd; v.divisor = dvs;
      v.divLat = lat; v.expNum = num; v.expDenom = den; v.expQuot = q; v.expRem = r;
      v.expErr = err; v.expDbz = dbz; v.expCycles = cyc;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      checkOutput({v.name, "_ready_idle"}, 32'(req_ready), 32'd1);
      req_wide     = v.wide;
      req_signed   = v.sgn;
      req_dividend = v.dividend;
      req_divisor  = v.divisor;
      req_valid    = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic waitResult(input int budget, input bit toggleCe, output bit got, output int ceCycles);
      got = 1'b0;
      ceCycles = 0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (res_valid) got = 1'b1;
         else begin
            if (toggleCe) ce = ~ce;
            @(posedge clk);
            if (ce) ceCycles++;
         end
      end
      ce = 1'b1;
   endtask

   task automatic runVector(input vec_t v, input bit toggleCe);
      bit got;
      int cyc;
      int s0;
      divLat = v.divLat;
      s0 = startCount;
      applyStimulus(v);
      checkOutput({v.name, "_num"},   div_num, v.expNum);
      checkOutput({v.name, "_denom"}, div_denom, v.expDenom);
      checkOutput({v.name, "_start"}, 32'(div_start), 32'd1);
      checkOutput({v.name, "_busy"},  32'(req_ready), 32'd0);
      checkOutput({v.name, "_wide"},  32'(div_wide), 32'(v.wide));
      checkOutput({v.name, "_sgn"},   32'(div_is_signed), 32'(v.sgn));
      waitResult(200, toggleCe, got, cyc);
      checkOutput({v.name, "_valid"},  32'(got), 32'd1);
      checkOutput({v.name, "_cycles"}, cyc, v.expCycles);
      checkOutput({v.name, "_quot"},   32'(res_quot), 32'(v.expQuot));
      checkOutput({v.name, "_rem"},    32'(res_rem), 32'(v.expRem));
      checkOutput({v.name, "_err"},    32'(res_err), 32'(v.expErr));
      checkOutput({v.name, "_dbz"},    32'(res_dbz), 32'(v.expDbz));
      @(negedge clk);
      checkOutput({v.name, "_strobe"}, 32'(res_valid), 32'd0);
      checkOutput({v.name, "_starts"}, startCount - s0, 32'd1);
   endtask

   initial begin
      bit   got;
      bit   doneSeen;
      bit   sawValid;
      int   cyc;
      int   n;
      int   s0;
      vec_t v;

      vecs.push_back(mkVec("ubyte",     0, 0, 32'h0000_0064, 16'h0007,  6, 32'h0000_0064, 32'h0000_0007, 16'h000E, 16'h0002, 0, 0, 14));
      vecs.push_back(mkVec("sword",     1, 1, 32'hFFFF_FF9C, 16'h0007,  6, 32'hFFFF_FF9C, 32'h0000_0007, 16'hFFF2, 16'hFFFE, 0, 0, 22));
      vecs.push_back(mkVec("dbz",       1, 0, 32'h0000_1234, 16'h0000,  6, 32'h0000_1234, 32'h0000_0000, 16'h0000, 16'h0000, 1, 1, 22));
      vecs.push_back(mkVec("ubyte_ovf", 0, 0, 32'h0000_1000, 16'h0010,  6, 32'h0000_1000, 32'h0000_0010, 16'h0000, 16'h0000, 1, 0, 14));
      vecs.push_back(mkVec("sbyte_min", 0, 1, 32'h0000_FF80, 16'h0001,  6, 32'hFFFF_FF80, 32'h0000_0001, 16'h0080, 16'h0000, 0, 0, 14));
      vecs.push_back(mkVec("sbyte_ovf", 0, 1, 32'h0000_0080, 16'h0001,  6, 32'h0000_0080, 32'h0000_0001, 16'h0000, 16'h0000, 1, 0, 14));
      vecs.push_back(mkVec("sbyte_nrem",0, 1, 32'h0000_FFF9, 16'h0002,  6, 32'hFFFF_FFF9, 32'h0000_0002, 16'h00FD, 16'h00FF, 0, 0, 14));
      vecs.push_back(mkVec("sbyte_ndiv",0, 1, 32'h1234_0064, 16'hABF9,  6, 32'h0000_0064, 32'hFFFF_FFF9, 16'h00F2, 16'h0002, 0, 0, 14));
      vecs.push_back(mkVec("ubyte_hi",  0, 0, 32'h0000_00C8, 16'hFF07,  6, 32'h0000_00C8, 32'h0000_0007, 16'h001C, 16'h0004, 0, 0, 14));
      vecs.push_back(mkVec("uword_max", 1, 0, 32'h0001_0000, 16'h0002,  6, 32'h0001_0000, 32'h0000_0002, 16'h8000, 16'h0000, 0, 0, 22));
      vecs.push_back(mkVec("uword_ovf", 1, 0, 32'h0002_0000, 16'h0001,  6, 32'h0002_0000, 32'h0000_0001, 16'h0000, 16'h0000, 1, 0, 22));
      vecs.push_back(mkVec("sword_ovf", 1, 1, 32'h0000_8000, 16'h0001,  6, 32'h0000_8000, 32'h0000_0001, 16'h0000, 16'h0000, 1, 0, 22));
      vecs.push_back(mkVec("sword_min", 1, 1, 32'hFFFF_8000, 16'h0001,  6, 32'hFFFF_8000, 32'h0000_0001, 16'h8000, 16'h0000, 0, 0, 22));
      vecs.push_back(mkVec("sword_ndiv",1, 1, 32'h0000_0064, 16'hFFF9,  6, 32'h0000_0064, 32'hFFFF_FFF9, 16'hFFF2, 16'h0002, 0, 0, 22));
      vecs.push_back(mkVec("slow_byte", 0, 0, 32'h0000_00FF, 16'h0010, 20, 32'h0000_00FF, 32'h0000_0010, 16'h000F, 16'h000F, 0, 0, 23));
      vecs.push_back(mkVec("slow_word", 1, 0, 32'h0000_0064, 16'h0007, 25, 32'h0000_0064, 32'h0000_0007, 16'h000E, 16'h0002, 0, 0, 28));

      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready",  32'(req_ready), 32'd1);
      checkOutput("rst_valid",  32'(res_valid), 32'd0);
      checkOutput("rst_err",    32'(res_err), 32'd0);
      checkOutput("rst_start",  32'(div_start), 32'd0);
      checkOutput("rst_quot",   32'(res_quot), 32'd0);
      checkOutput("rst_num",    div_num, 32'd0);
      checkOutput("rst_div_ce", 32'(div_ce), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) runVector(vecs[i], 1'b0);

      v = vecs[0];
      v.name = "ce_toggle";
      runVector(v, 1'b1);

      // Abort coinciding with a would-be accept
      @(negedge clk);
      req_wide = 1'b0; req_signed = 1'b0; req_dividend = 32'h64; req_divisor = 16'h7;
      req_valid = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      req_valid = 1'b0;
      checkOutput("abort_accept_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_accept_start", 32'(div_start), 32'd0);
      waitResult(30, 1'b0, got, cyc);
      checkOutput("abort_accept_noresp", 32'(got), 32'd0);

      // Abort in WAIT followed at once by a new request
      divLat = 10;
      s0 = startCount;
      v = vecs[0];
      v.name = "abort_first";
      applyStimulus(v);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      req_wide = 1'b0; req_signed = 1'b0; req_dividend = 32'h0000_0009; req_divisor = 16'h0003;
      req_valid = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      n = 0;
      doneSeen = 1'b0;
      sawValid = 1'b0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         doneSeen |= mDone;
         if (res_valid) sawValid = 1'b1;
         @(negedge clk);
         n++;
      end
      checkOutput("drain_ready",    32'(req_ready), 32'd1);
      checkOutput("drain_cycles",   n, 32'd8);
      checkOutput("drain_done",     32'(doneSeen), 32'd1);
      checkOutput("drain_novalid",  32'(sawValid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      checkOutput("second_num",   div_num, 32'h0000_0009);
      checkOutput("second_denom", div_denom, 32'h0000_0003);
      waitResult(200, 1'b0, got, cyc);
      checkOutput("second_valid",  32'(got), 32'd1);
      checkOutput("second_cycles", cyc, 32'd14);
      checkOutput("second_quot",   32'(res_quot), 32'h0003);
      checkOutput("second_rem",    32'(res_rem), 32'h0000);
      checkOutput("second_err",    32'(res_err), 32'd0);
      @(negedge clk);
      checkOutput("abort_starts",  startCount - s0, 32'd2);

      // Reset pulsed while the sequencer is padding
      v = vecs[0];
      v.name = "reset_pad";
      v.divLat = 4;
      divLat = 4;
      applyStimulus(v);
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("rstpad_ready", 32'(req_ready), 32'd1);
      checkOutput("rstpad_valid", 32'(res_valid), 32'd0);
      checkOutput("rstpad_start", 32'(div_start), 32'd0);
      checkOutput("rstpad_num",   div_num, 32'd0);
      checkOutput("rstpad_denom", div_denom, 32'd0);
      checkOutput("rstpad_quot",  32'(res_quot), 32'd0);
      checkOutput("rstpad_rem",   32'(res_rem), 32'd0);
      checkOutput("rstpad_err",   32'(res_err), 32'd0);
      checkOutput("rstpad_dbz",   32'(res_dbz), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      waitResult(40, 1'b0, got, cyc);
      checkOutput("rstpad_noresp", 32'(got), 32'd0);

      runVector(vecs[1], 1'b0);

      checkOutput("no_start_while_busy", 32'(startWhileBusy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
